count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_seq_pkg.sv | 19 +
 rtl/count_core.sv | 43 ++++
 rtl/count_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_count_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types for the count sequencer: FSM state encoding and sequence mode codes.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP_ONCE   = 2'b00;
  localparam logic [1:0] MODE_DOWN_ONCE = 2'b01;
  localparam logic [1:0] MODE_UP_RELOAD = 2'b10;
  localparam logic [1:0] MODE_PING_PONG = 2'b11;

  function automatic logic mode_counts_up(input logic [1:0] m);
    return m != MODE_DOWN_ONCE;
  endfunction

endpackage

// File: rtl/count_core.sv
// Counter register for the sequencer: synchronous load, enabled up/down step,
// and zero / terminal-value flags on the current count.
module count_core #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] limit,
  output logic [N-1:0] count,
  output logic         at_zero,
  output logic         at_limit
);

  logic [N-1:0] count_reg;
  logic [N-1:0] count_next;

  // Load takes priority over stepping; steps wrap modulo 2^N.
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (en) begin
      count_next = up ? count_reg + 1'b1 : count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count    = count_reg;
  assign at_zero  = (count_reg == '0);
  assign at_limit = (count_reg == limit);

endmodule

// File: rtl/count_sequencer.sv
// Sequenced up/down counter with one-shot, auto-reload and ping-pong modes.
// Define COUNT_SEQ_PRESCALE_EN to add the prescale port and tick divider.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     limit,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PRE_W-1:0] prescale,
`endif
  output logic [N-1:0]     count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t       state_reg, state_next;
  logic [1:0]   mode_reg, mode_next;
  logic [N-1:0] limit_reg, limit_next;
  logic         dir_reg, dir_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;
  logic         wrap_reg, wrap_next;

  logic         tick;
  logic         accept;
  logic         core_load;
  logic [N-1:0] core_load_val;
  logic         core_en;
  logic         core_up;
  logic         at_zero;
  logic         at_limit;

  assign accept = (state_reg == IDLE) && start && !stop;

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRE_W-1:0] prescale_reg;
  logic [PRE_W-1:0] pre_cnt_reg;

  // The first RUN cycle after LOAD ticks, then one tick per prescale+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_reg <= '0;
      pre_cnt_reg  <= '0;
    end else begin
      if (accept) begin
        prescale_reg <= prescale;
      end
      if (state_reg == LOAD) begin
        pre_cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        pre_cnt_reg <= (pre_cnt_reg == prescale_reg) ? '0 : pre_cnt_reg + 1'b1;
      end
    end
  end

  assign tick = (pre_cnt_reg == '0);
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      mode_reg  <= '0;
      limit_reg <= '0;
      dir_reg   <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      limit_reg <= limit_next;
      dir_reg   <= dir_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      wrap_reg  <= wrap_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    limit_next    = limit_reg;
    dir_next      = dir_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    wrap_next     = 1'b0;
    core_load     = 1'b0;
    core_load_val = '0;
    core_en       = 1'b0;
    core_up       = dir_reg;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (accept) begin
          mode_next  = mode;
          limit_next = limit;
          state_next = LOAD;
        end
      end

      LOAD: begin
        if (stop) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          core_load     = 1'b1;
          core_load_val = mode_counts_up(mode_reg) ? '0 : limit_reg;
          dir_next      = mode_counts_up(mode_reg);
          busy_next     = 1'b1;
          state_next    = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (tick) begin
          case (mode_reg)
            MODE_UP_ONCE, MODE_DOWN_ONCE: begin
              if ((mode_reg == MODE_UP_ONCE) ? at_limit : at_zero) begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
              end else begin
                core_en = 1'b1;
              end
            end
            MODE_UP_RELOAD: begin
              if (at_limit) begin
                core_load = 1'b1;
                wrap_next = 1'b1;
              end else begin
                core_en = 1'b1;
              end
            end
            default: begin
              // Ping-pong: a zero limit has no room to move, so only reverse.
              if (limit_reg == '0) begin
                dir_next  = !dir_reg;
                wrap_next = 1'b1;
              end else if (dir_reg && at_limit) begin
                dir_next  = 1'b0;
                core_up   = 1'b0;
                core_en   = 1'b1;
                wrap_next = 1'b1;
              end else if (!dir_reg && at_zero) begin
                dir_next  = 1'b1;
                core_up   = 1'b1;
                core_en   = 1'b1;
                wrap_next = 1'b1;
              end else begin
                core_en = 1'b1;
              end
            end
          endcase
        end
      end

      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  count_core #(.N(N)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (core_load_val),
    .en       (core_en),
    .up       (core_up),
    .limit    (limit_reg),
    .count    (count),
    .at_zero  (at_zero),
    .at_limit (at_limit)
  );

  assign dir  = dir_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: expected per-cycle outputs are queued
// when a scenario is set up and popped one per clock as the DUT runs.
module tb_count_sequencer;

  typedef struct packed {
    logic [7:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] limit = 8'd0;
  logic [7:0] count;
  logic       dir, busy, done, wrap;
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [3:0] prescale = 4'd0;
`endif

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  count_sequencer #(.N(8), .PRE_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .limit    (limit),
`ifdef COUNT_SEQ_PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  function automatic exp_t mk(input int c, input bit d, input bit b, input bit dn, input bit w);
    exp_t e;
    e.count = 8'(c);
    e.dir   = d;
    e.busy  = b;
    e.done  = dn;
    e.wrap  = w;
    return e;
  endfunction

  task automatic start_seq(input logic [1:0] m, input logic [7:0] l);
    @(negedge clk);
    mode  = m;
    limit = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e, got;
    exp_q.push_back(mk(0, 1, 0, 0, 0));
    #12;
    got = {count, dir, busy, done, wrap};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL reset: got %h expected %h", got, e);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset: reset values checked");
  endtask

  task automatic test_one_shot_up;
    exp_t e, got;
    for (int i = 0; i <= 3; i++) exp_q.push_back(mk(i, 1, 1, 0, 0));
    exp_q.push_back(mk(3, 1, 0, 1, 0));
    exp_q.push_back(mk(3, 1, 0, 0, 0));
    start_seq(2'b00, 8'd3);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL one_shot_up[%0d]: got %h expected %h", i, got, e);
      end
    end
    $display("test_one_shot_up: mode 00 limit 3 sequence checked");
  endtask

  task automatic test_start_stop_idle;
    exp_t e, got;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(3, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = (i == 0);
      stop  = (i == 0);
      mode  = 2'b01;
      limit = 8'd7;
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL start_stop_idle[%0d]: got %h expected %h", i, got, e);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    $display("test_start_stop_idle: start with stop in IDLE ignored");
  endtask

  task automatic test_ping_pong;
    exp_t e, got;
    exp_q.push_back(mk(0, 1, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 1, 0, 0));
    exp_q.push_back(mk(2, 1, 1, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 0, 1));
    exp_q.push_back(mk(0, 0, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 1, 0, 1));
    exp_q.push_back(mk(2, 1, 1, 0, 0));
    exp_q.push_back(mk(2, 1, 0, 0, 0));
    start_seq(2'b11, 8'd2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      stop = (i == 7);
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL ping_pong[%0d]: got %h expected %h", i, got, e);
      end
    end
    stop = 1'b0;
    $display("test_ping_pong: mode 11 limit 2 sequence checked");
  endtask

  task automatic test_down_stop;
    exp_t e, got;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(5 - i, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(3, 0, 0, 0, 0));
    start_seq(2'b01, 8'd5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stop = (i == 3);
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL down_stop[%0d]: got %h expected %h", i, got, e);
      end
    end
    stop = 1'b0;
    $display("test_down_stop: mode 01 limit 5 aborted at 3");
  endtask

  task automatic test_down_done;
    exp_t e, got;
    exp_q.push_back(mk(1, 0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    start_seq(2'b01, 8'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL down_done[%0d]: got %h expected %h", i, got, e);
      end
    end
    $display("test_down_done: mode 01 limit 1 completion checked");
  endtask

  task automatic test_ping_pong_zero;
    exp_t e, got;
    exp_q.push_back(mk(0, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 1, 1, 0, 1));
    exp_q.push_back(mk(0, 1, 0, 0, 0));
    start_seq(2'b11, 8'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stop = (i == 4);
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if ({got.count, got.busy, got.done, got.wrap} !== {e.count, e.busy, e.done, e.wrap}) begin
        n_err++;
        $display("FAIL ping_pong_zero[%0d]: got count/busy/done/wrap %h/%b%b%b expected %h/%b%b%b",
                 i, got.count, got.busy, got.done, got.wrap, e.count, e.busy, e.done, e.wrap);
      end
    end
    stop = 1'b0;
    $display("test_ping_pong_zero: limit 0 holds count and wraps each tick");
  endtask

  task automatic test_auto_reload;
    exp_t e, got;
    for (int i = 0; i <= 255; i++) exp_q.push_back(mk(i, 1, 1, 0, 0));
    exp_q.push_back(mk(0, 1, 1, 0, 1));
    exp_q.push_back(mk(1, 1, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 0, 0));
    start_seq(2'b10, 8'd255);
    for (int i = 0; i < 259; i++) begin
      @(negedge clk);
      stop = (i == 258);
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL auto_reload[%0d]: got %h expected %h", i, got, e);
      end
    end
    stop = 1'b0;
    $display("test_auto_reload: mode 10 limit 255 wrap checked");
  endtask

  task automatic test_back_to_back;
    exp_t e, got;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(mk(0, 1, 1, 0, 0));
      exp_q.push_back(mk(1, 1, 1, 0, 0));
      exp_q.push_back(mk(1, 1, 0, 1, 0));
      exp_q.push_back(mk(1, 1, 0, 0, 0));
    end
    @(negedge clk);
    mode  = 2'b00;
    limit = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = (i <= 3);
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, e);
      end
    end
    start = 1'b0;
    $display("test_back_to_back: held start relaunches after done");
  endtask

  task automatic test_busy_restart;
    exp_t e, got;
    for (int i = 0; i <= 4; i++) exp_q.push_back(mk(i, 1, 1, 0, 0));
    exp_q.push_back(mk(4, 1, 0, 1, 0));
    exp_q.push_back(mk(4, 1, 0, 0, 0));
    start_seq(2'b00, 8'd4);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = (i == 2);
      if (i == 2) begin
        mode  = 2'b01;
        limit = 8'd9;
      end
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL busy_restart[%0d]: got %h expected %h", i, got, e);
      end
    end
    start = 1'b0;
    $display("test_busy_restart: start while running ignored");
  endtask

  task automatic test_async_reset;
    exp_t e, got;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(i, 1, 1, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 0, 0));
    start_seq(2'b00, 8'd10);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL async_reset_run[%0d]: got %h expected %h", i, got, e);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    got = {count, dir, busy, done, wrap};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL async_reset_immediate: got %h expected %h", got, e);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL async_reset_idle[%0d]: got %h expected %h", i, got, e);
      end
    end
    $display("test_async_reset: mid-run reset aborts immediately");
  endtask

`ifdef COUNT_SEQ_PRESCALE_EN
  task automatic test_prescale;
    exp_t e, got;
    exp_q.push_back(mk(0, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(2, 1, 1, 0, 0));
    exp_q.push_back(mk(2, 1, 0, 1, 0));
    exp_q.push_back(mk(2, 1, 0, 0, 0));
    @(negedge clk);
    prescale = 4'd2;
    start_seq(2'b00, 8'd2);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      got = {count, dir, busy, done, wrap};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL prescale[%0d]: got %h expected %h", i, got, e);
      end
    end
    prescale = 4'd0;
    $display("test_prescale: prescale 2 tick spacing checked");
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot_up();
    test_start_stop_idle();
    test_ping_pong();
    test_down_stop();
    test_down_done();
    test_ping_pong_zero();
    test_auto_reload();
    test_back_to_back();
    test_busy_restart();
    test_async_reset();
`ifdef COUNT_SEQ_PRESCALE_EN
    test_prescale();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
